// File: rtl/calc_entry_ctrl_pkg.sv
// Shared encodings for the calculator keypad entry controller.
package calc_entry_ctrl_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned KEY_W      = 5;
    localparam int unsigned MAX_DIGITS = 4;

    typedef enum logic [1:0] {
        S_LA  = 2'd0,
        S_LB  = 2'd1,
        S_OBL = 2'd2
    } entry_state_t;

    typedef enum logic [2:0] {
        SL_ADD  = 3'd0,
        SL_SUB  = 3'd1,
        SL_XOR  = 3'd2,
        SL_AND  = 3'd3,
        SL_OR   = 3'd4,
        SL_NONE = 3'd7
    } op_sel_t;

    typedef enum logic [2:0] {
        KC_NONE,
        KC_DIGIT,
        KC_OP,
        KC_EQ,
        KC_CLR,
        KC_BKSP
    } key_class_t;

    localparam logic [KEY_W-1:0] K_ADD  = 5'd16;
    localparam logic [KEY_W-1:0] K_SUB  = 5'd17;
    localparam logic [KEY_W-1:0] K_XOR  = 5'd18;
    localparam logic [KEY_W-1:0] K_AND  = 5'd19;
    localparam logic [KEY_W-1:0] K_OR   = 5'd20;
    localparam logic [KEY_W-1:0] K_EQ   = 5'd21;
    localparam logic [KEY_W-1:0] K_CLR  = 5'd22;
    localparam logic [KEY_W-1:0] K_BKSP = 5'd23;

    // Operation selected by an op key; SL_NONE for anything else.
    function automatic op_sel_t op_of(input logic [KEY_W-1:0] code);
        op_sel_t op;
        case (code)
            K_ADD:   op = SL_ADD;
            K_SUB:   op = SL_SUB;
            K_XOR:   op = SL_XOR;
            K_AND:   op = SL_AND;
            K_OR:    op = SL_OR;
            default: op = SL_NONE;
        endcase
        return op;
    endfunction

    function automatic key_class_t classify(input logic [KEY_W-1:0] code);
        key_class_t kc;
        if (code <= 5'd9)               kc = KC_DIGIT;
        else if (op_of(code) != SL_NONE) kc = KC_OP;
        else if (code == K_EQ)          kc = KC_EQ;
        else if (code == K_CLR)         kc = KC_CLR;
        else if (code == K_BKSP)        kc = KC_BKSP;
        else                            kc = KC_NONE;
        return kc;
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_entry_reg.sv
// bcd_entry_reg: 4-digit BCD shift register with a digit count, one per operand.
module bcd_entry_reg
    import calc_entry_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               shl,
    input  logic               shr,
    input  logic               clr,
    input  logic               load1,
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] D1,
    output logic [DIGIT_W-1:0] D2,
    output logic [DIGIT_W-1:0] D3,
    output logic [DIGIT_W-1:0] D4,
    output logic [CNT_W-1:0]   cnt,
    output logic               full,
    output logic               empty
);

    assign full  = (cnt == CNT_W'(MAX_DIGITS));
    assign empty = (cnt == '0);

    // clr wins over load1, which wins over shifts; shifts saturate at the ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D1  <= '0;
            D2  <= '0;
            D3  <= '0;
            D4  <= '0;
            cnt <= '0;
        end else if (clr) begin
            D1  <= '0;
            D2  <= '0;
            D3  <= '0;
            D4  <= '0;
            cnt <= '0;
        end else if (load1) begin
            D1  <= '0;
            D2  <= '0;
            D3  <= '0;
            D4  <= din;
            cnt <= (din != '0) ? CNT_W'(1) : CNT_W'(0);
        end else if (shl && !full) begin
            D1  <= D2;
            D2  <= D3;
            D3  <= D4;
            D4  <= din;
            cnt <= cnt + CNT_W'(1);
        end else if (shr && !empty) begin
            D4  <= D3;
            D3  <= D2;
            D2  <= D1;
            D1  <= '0;
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller: key edge detect, decode and entry FSM driving
// two BCD operand registers, the operation select and the calculator state.
module calc_entry_ctrl
    import calc_entry_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    output logic [DIGIT_W-1:0] A1,
    output logic [DIGIT_W-1:0] A2,
    output logic [DIGIT_W-1:0] A3,
    output logic [DIGIT_W-1:0] A4,
    output logic [DIGIT_W-1:0] B1,
    output logic [DIGIT_W-1:0] B2,
    output logic [DIGIT_W-1:0] B3,
    output logic [DIGIT_W-1:0] B4,
    output logic [1:0]         ST,
    output logic [2:0]         ST_L,
    output logic               entry_err
);

    entry_state_t st, st_nxt;
    op_sel_t      st_l, st_l_nxt;
    logic         prev_valid;
    logic         err_nxt;

    logic a_shl, a_shr, a_clr, a_load, a_full, a_empty;
    logic b_shl, b_shr, b_clr, b_full, b_empty;
    logic [CNT_W-1:0] a_cnt, b_cnt;

    logic               key_event_c;
    key_class_t         kc_c;
    op_sel_t            op_c;
    logic [DIGIT_W-1:0] digit_c;

    assign key_event_c = key_valid && !prev_valid;
    assign kc_c        = classify(key_code);
    assign op_c        = op_of(key_code);
    assign digit_c     = key_code[DIGIT_W-1:0];

    // prev_valid resets high so a key held through reset never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_valid <= 1'b1;
            st         <= S_LA;
            st_l       <= SL_NONE;
            entry_err  <= 1'b0;
        end else begin
            prev_valid <= key_valid;
            st         <= st_nxt;
            st_l       <= st_l_nxt;
            entry_err  <= err_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        st_l_nxt = st_l;
        err_nxt  = 1'b0;
        a_shl    = 1'b0;
        a_shr    = 1'b0;
        a_clr    = 1'b0;
        a_load   = 1'b0;
        b_shl    = 1'b0;
        b_shr    = 1'b0;
        b_clr    = 1'b0;
        if (key_event_c) begin
            if (kc_c == KC_CLR) begin
                a_clr    = 1'b1;
                b_clr    = 1'b1;
                st_l_nxt = SL_NONE;
                st_nxt   = S_LA;
            end else begin
                case (st)
                    S_LA: begin
                        case (kc_c)
                            // a leading zero is accepted but not stored
                            KC_DIGIT: if (a_full) err_nxt = 1'b1;
                                      else a_shl = !(a_cnt == '0 && digit_c == '0);
                            KC_BKSP:  if (a_empty) err_nxt = 1'b1;
                                      else a_shr = 1'b1;
                            KC_OP: begin
                                st_l_nxt = op_c;
                                b_clr    = 1'b1;
                                st_nxt   = S_LB;
                            end
                            KC_EQ:    err_nxt = 1'b1;
                            default:  ;
                        endcase
                    end
                    S_LB: begin
                        case (kc_c)
                            KC_DIGIT: if (b_full) err_nxt = 1'b1;
                                      else b_shl = !(b_cnt == '0 && digit_c == '0);
                            KC_BKSP:  if (b_empty) err_nxt = 1'b1;
                                      else b_shr = 1'b1;
                            KC_OP:    if (b_empty) st_l_nxt = op_c;
                                      else err_nxt = 1'b1;
                            KC_EQ:    st_nxt = S_OBL;
                            default:  ;
                        endcase
                    end
                    S_OBL: begin
                        case (kc_c)
                            KC_DIGIT: begin
                                a_load   = 1'b1;
                                b_clr    = 1'b1;
                                st_l_nxt = SL_NONE;
                                st_nxt   = S_LA;
                            end
                            KC_OP, KC_BKSP: err_nxt = 1'b1;
                            default: ;
                        endcase
                    end
                    default: st_nxt = S_LA;
                endcase
            end
        end
    end

    assign ST   = st;
    assign ST_L = st_l;

    bcd_entry_reg u_reg_a (
        .clk   (clk),
        .rst   (rst),
        .shl   (a_shl),
        .shr   (a_shr),
        .clr   (a_clr),
        .load1 (a_load),
        .din   (digit_c),
        .D1    (A1),
        .D2    (A2),
        .D3    (A3),
        .D4    (A4),
        .cnt   (a_cnt),
        .full  (a_full),
        .empty (a_empty)
    );

    bcd_entry_reg u_reg_b (
        .clk   (clk),
        .rst   (rst),
        .shl   (b_shl),
        .shr   (b_shr),
        .clr   (b_clr),
        .load1 (1'b0),
        .din   (digit_c),
        .D1    (B1),
        .D2    (B2),
        .D3    (B3),
        .D4    (B4),
        .cnt   (b_cnt),
        .full  (b_full),
        .empty (b_empty)
    );

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl with hand-computed expectations.
module tb_calc_entry_ctrl;

    localparam logic [4:0] KADD = 5'd16, KSUB = 5'd17, KXOR = 5'd18, KOR = 5'd20;
    localparam logic [4:0] KEQ  = 5'd21, KCLR = 5'd22, KBK  = 5'd23;
    localparam int unsigned LA = 0, LB = 1, OBL = 2;
    localparam int unsigned OADD = 0, OSUB = 1, OXOR = 2, ONONE = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [4:0] key_code;
    logic [3:0] A1, A2, A3, A4, B1, B2, B3, B4;
    logic [1:0] ST;
    logic [2:0] ST_L;
    logic       entry_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        e1, e2;

    calc_entry_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4),
        .B1(B1), .B2(B2), .B3(B3), .B4(B4),
        .ST(ST), .ST_L(ST_L), .entry_err(entry_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned a_val();
        return int'({A1, A2, A3, A4});
    endfunction

    function automatic int unsigned b_val();
        return int'({B1, B2, B3, B4});
    endfunction

    // One clean key press; e1 = entry_err the cycle after the edge, e2 = the cycle after that.
    task automatic press(input logic [4:0] code, output logic err1, output logic err2);
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        err1 = entry_err;
        @(negedge clk);
        err2 = entry_err;
        key_valid = 1'b0;
        key_code  = 5'h1f;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 5'd0;
        repeat (2) @(negedge clk);
        chk("reset_a", a_val(), 0);
        chk("reset_b", b_val(), 0);
        chk("reset_st", ST, LA);
        chk("reset_stl", ST_L, ONONE);
        chk("reset_err", entry_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Four digits fill A, the fifth is rejected with a single-cycle pulse
        for (int d = 1; d <= 4; d++) begin
            press(5'(d), e1, e2);
            chk("fill_err", e1, 0);
        end
        chk("fill_a", a_val(), 'h1234);
        press(5'd5, e1, e2);
        chk("full_err", e1, 1);
        chk("full_err_off", e2, 0);
        chk("full_a", a_val(), 'h1234);
        chk("full_st", ST, LA);

        // 12 ADD 7 EQ
        press(KCLR, e1, e2);
        press(5'd1, e1, e2);
        press(5'd2, e1, e2);
        press(KADD, e1, e2);
        chk("add_st", ST, LB);
        chk("add_b0", b_val(), 0);
        press(5'd7, e1, e2);
        press(KEQ, e1, e2);
        chk("eq_st", ST, OBL);
        chk("eq_err", e1, 0);
        chk("eq_a", a_val(), 'h0012);
        chk("eq_b", b_val(), 'h0007);
        chk("eq_stl", ST_L, OADD);

        // Digit from S_OBL starts a fresh entry
        press(5'd9, e1, e2);
        chk("obl9_st", ST, LA);
        chk("obl9_a", a_val(), 'h0009);
        chk("obl9_b", b_val(), 0);
        chk("obl9_stl", ST_L, ONONE);

        // Empty B is allowed; then BKSP rejected in S_OBL, EQ a no-op
        press(KADD, e1, e2);
        press(KEQ, e1, e2);
        chk("eq_emptyb_st", ST, OBL);
        press(KBK, e1, e2);
        chk("obl_bk_err", e1, 1);
        press(KSUB, e1, e2);
        chk("obl_op_err", e1, 1);
        press(KEQ, e1, e2);
        chk("obl_eq_err", e1, 0);
        chk("obl_eq_st", ST, OBL);
        chk("obl_eq_stl", ST_L, OADD);

        // Op replacement while B is empty, rejection once B has a digit
        press(KCLR, e1, e2);
        press(5'd1, e1, e2);
        press(KSUB, e1, e2);
        press(KXOR, e1, e2);
        chk("repl_err", e1, 0);
        chk("repl_stl", ST_L, OXOR);
        press(5'd5, e1, e2);
        press(KOR, e1, e2);
        chk("lock_err", e1, 1);
        chk("lock_stl", ST_L, OXOR);
        chk("lock_b", b_val(), 'h0005);
        press(KBK, e1, e2);
        chk("bk_b", b_val(), 0);
        chk("bk_err", e1, 0);
        press(KBK, e1, e2);
        chk("bk_empty_err", e1, 1);

        // CLR from S_LB
        press(5'd3, e1, e2);
        press(KCLR, e1, e2);
        chk("clr_err", e1, 0);
        chk("clr_a", a_val(), 0);
        chk("clr_b", b_val(), 0);
        chk("clr_st", ST, LA);
        chk("clr_stl", ST_L, ONONE);

        // A held key acts once
        @(negedge clk);
        key_code  = 5'd3;
        key_valid = 1'b1;
        repeat (20) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        chk("hold_a", a_val(), 'h0003);

        // Leading zeros are dropped and the count stays at zero
        press(KCLR, e1, e2);
        press(5'd0, e1, e2);
        chk("zero_err", e1, 0);
        press(5'd0, e1, e2);
        chk("zero_a", a_val(), 0);
        press(KBK, e1, e2);
        chk("zero_bk_err", e1, 1);
        for (int d = 1; d <= 4; d++) press(5'(d), e1, e2);
        chk("zero_cnt_err", e1, 0);
        chk("zero_cnt_a", a_val(), 'h1234);

        // Unknown codes and EQ in S_LA
        press(5'd12, e1, e2);
        chk("ign_err", e1, 0);
        chk("ign_a", a_val(), 'h1234);
        press(KEQ, e1, e2);
        chk("la_eq_err", e1, 1);
        chk("la_eq_st", ST, LA);

        // BKSP in A shifts right
        press(KBK, e1, e2);
        chk("a_bk", a_val(), 'h0123);

        // Async reset while a key is held
        press(KCLR, e1, e2);
        press(5'd1, e1, e2);
        press(5'd2, e1, e2);
        @(negedge clk);
        key_code  = 5'd5;
        key_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_a", a_val(), 'h0125);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_a", a_val(), 0);
        chk("async_rst_st", ST, LA);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_ignored_a", a_val(), 0);
        key_valid = 1'b0;
        @(negedge clk);
        press(5'd6, e1, e2);
        chk("post_rst_a", a_val(), 'h0006);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keypad entry controller sitting directly upstream of the BCD calculator core. It turns a stream of debounced key codes into two 4-digit BCD operands, an operation code and the calculator state word. The calculator core reads these and shows its result only while the state is `S_OBL`. Each key press is acted on exactly once, on the rising edge of its valid line.

## Interface
Parameters: none. Encodings live in `defines.vh`.

Ports:
- `clk` in 1 — system clock, all state updates on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `key_valid` in 1 — level from keypad debouncer; high while a key is held.
- `key_code` in 5 — key identity; sampled in the cycle `key_valid` rises.
- `A1,A2,A3,A4` out 4 each — operand A BCD digits; A1 thousands … A4 ones.
- `B1,B2,B3,B4` out 4 each — operand B BCD digits; same ordering.
- `ST` out 2 — entry state: `S_LA`, `S_LB` or `S_OBL`.
- `ST_L` out 3 — operation: `SL_ADD`, `SL_SUB`, `SL_XOR`, `SL_AND`, `SL_OR` or `SL_NONE`.
- `entry_err` out 1 — one-cycle pulse when an accepted key edge is rejected.

## Operation
Key codes:
- 0–9: digits.
- 16–20: ADD, SUB, XOR, AND, OR.
- 21: EQ.
- 22: CLR.
- 23: BKSP.
- Any other code: ignored; no error.

Key event:
- A key event is `key_valid` high in a cycle where the registered previous `key_valid` was low.
- A held key produces exactly one event.

Digit entry, per operand, with a counter `cnt` in 0..4:
- Digit `d` with `cnt`<4 shifts left: D1←D2, D2←D3, D3←D4, D4←d, then `cnt`+1.
- Digit 0 with `cnt`=0 is accepted but leaves the register and `cnt` unchanged (no leading zeros).
- Digit with `cnt`=4: rejected.
- BKSP with `cnt`>0 shifts right: D4←D3, D3←D2, D2←D1, D1←0, then `cnt`−1.
- BKSP with `cnt`=0: rejected.

State machine:
- **S_LA**
  - Digit or BKSP edits A.
  - Op key: `ST_L`←op, B←0, B `cnt`←0, go to `S_LB`.
  - EQ: rejected.
- **S_LB**
  - Digit or BKSP edits B.
  - Op key with B `cnt`=0: replaces `ST_L`.
  - Op key with B `cnt`>0: rejected.
  - EQ: go to `S_OBL`. B may be zero.
- **S_OBL**
  - Digit: A←000d, A `cnt`←(d≠0), B←0, `ST_L`←`SL_NONE`, go to `S_LA`.
  - EQ: no-op.
  - Op key or BKSP: rejected.
- **CLR, any state:** A←0, B←0, both `cnt`←0, `ST_L`←`SL_NONE`, go to `S_LA`. Never rejected.

Reset values:
- A, B, both `cnt`: 0.
- `ST`=`S_LA`.
- `ST_L`=`SL_NONE`.
- `entry_err`=0.
- Previous-valid register resets to **1**. A key held through reset is ignored until it is released.

## Timing
- Key event detected in cycle N; all register updates are visible from cycle N+1.
- `entry_err` is high for cycle N+1 only.
- No further event is possible before N+2, because `key_valid` must drop and rise again.
- Operand digits, `ST` and `ST_L` are all registered outputs with no combinational path from inputs.
- Asserting `rst` mid-entry clears every register immediately and asynchronously; the next edge after release is processed normally.
- `key_code` must be stable in the edge cycle; values in later cycles are ignored.

## Structure
Add to `defines.vh`:
- `S_LA`=2'd0, `S_LB`=2'd1, `S_OBL`=2'd2 (2'd3 reserved, never driven).
- `SL_ADD`..`SL_OR`=3'd0..3'd4, `SL_NONE`=3'd7.
- `K_ADD`..`K_BKSP`=5'd16..5'd23.

Sub-module:
- `bcd_entry_reg`: 4-digit BCD shift register plus `cnt`.
- Inputs: `clk`, `rst`, `shl`, `shr`, `clr`, `load1`, `din[3:0]`.
- Outputs: `D1..D4`, `cnt[2:0]`, `full`, `empty`.
- Instantiated twice, once for A and once for B.
- The top level holds the FSM, edge detector, key decode and error pulse.

## Test plan
- Reset; press 1,2,3,4,5 → A=1,2,3,4; fifth digit gives `entry_err` pulse; `ST`=`S_LA`.
- A=0012; ADD; 7; EQ → B=0,0,0,7, `ST_L`=`SL_ADD`, `ST`=`S_OBL` one cycle after the EQ edge.
- In `S_LB` with B empty: SUB then XOR → `ST_L`=`SL_XOR`, no error. Then 5, OR → `entry_err`, `ST_L` stays `SL_XOR`.
- Hold `key_valid`=1 with code 3 for 20 cycles → A4=3 exactly once. 0, 0 in empty A → A=0000, `cnt` stays 0. BKSP on empty → error.
- In `S_OBL`, press 9 → `ST`=`S_LA`, A=0009, B=0, `ST_L`=`SL_NONE`. CLR from `S_LB` → all cleared.
- Assert `rst` while `key_valid`=1 mid-entry → outputs cleared immediately; no event until `key_valid` falls and rises again.
